// File: rtl/ct_spsram_param_clr.sv
// ct_spsram_param_clr
// Parametrised single-port SRAM for MMU/cache arrays.
//  - Active-low CEN / GWEN / WEN macro-style access port.
//  - Grouped write mask: WEN[i] covers D[i*G +: G], G = DATA_WIDTH / WE_WIDTH.
//  - Optional extra read-output register (RD_PIPE).
//  - Clear engine (INIT_EN) zeroes every entry after reset or on clr_req.
//  - q_vld marks the cycle Q carries fresh read data.
//  - init_busy tells the owning controller that user accesses are dropped.

module ct_spsram_param_clr #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 196,
  parameter int WE_WIDTH   = 196,
  parameter int RD_PIPE    = 0,
  parameter int INIT_EN    = 1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [WE_WIDTH-1:0]   WEN,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  q_vld,
  input  logic                  clr_req,
  output logic                  init_busy
);

  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam int GROUP_W = DATA_WIDTH / WE_WIDTH;

  // A mask group must cover a whole number of data bits.
  if ((DATA_WIDTH % WE_WIDTH) != 0) begin : g_bad_we_width
    $error("ct_spsram_param_clr: DATA_WIDTH must be a multiple of WE_WIDTH");
  end

  typedef enum logic {
    ST_READY = 1'b0,
    ST_INIT  = 1'b1
  } state_t;

  // Without the clear engine the array simply comes up READY.
  localparam state_t RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_READY;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    user_en;
  logic                    user_wr;
  logic                    user_rd;
  logic                    clr_wr;

  // ------------------------------------------------------------------
  // Access decode. User traffic only reaches the array in READY; the
  // clear sweep owns the port for the whole of INIT.
  // NOTE: continuous assigns for pure decode cannot infer a latch.
  // ------------------------------------------------------------------
  assign user_en   = (state == ST_READY) && !CEN;
  assign user_wr   = user_en && !GWEN;
  assign user_rd   = user_en &&  GWEN;
  assign clr_wr    = (state == ST_INIT);
  assign init_busy = (state == ST_INIT);

  // Clear-engine FSM: sweeps cnt 0..DEPTH-1, one entry per cycle.
  // NOTE: all state here uses non-blocking assignment so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_INIT: begin
          // cnt wraps to zero on the terminal entry, ready for next sweep.
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= ST_READY;
          end
        end
        ST_READY: begin
          // The access presented alongside clr_req is still served this
          // cycle; the sweep begins on the next edge from entry 0.
          if ((INIT_EN != 0) && clr_req) begin
            state <= ST_INIT;
            cnt   <= '0;
          end
        end
        default: begin
          state <= RST_STATE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Array write port: clear sweep or masked user write.
  // NOTE: the storage array has no reset; it maps onto an SRAM macro and
  // zeroing is the clear engine's job.
  always_ff @(posedge forever_cpuclk) begin
    if (clr_wr) begin
      mem[cnt] <= '0;
    end else if (user_wr) begin
      for (int i = 0; i < WE_WIDTH; i++) begin
        if (!WEN[i]) begin
          mem[A][i*GROUP_W +: GROUP_W] <= D[i*GROUP_W +: GROUP_W];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Read output path. Q only ever changes when a read completes, so it
  // holds across writes, idle cycles and the clear sweep.
  // ------------------------------------------------------------------
  if (RD_PIPE == 0) begin : g_rd_direct

    // Single stage: array data lands on Q at the edge after the read.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
        Q     <= '0;
        q_vld <= 1'b0;
      end else begin
        q_vld <= user_rd;
        if (user_rd) begin
          Q <= mem[A];
        end
      end
    end

  end else begin : g_rd_pipe

    logic [DATA_WIDTH-1:0] pipe_data;
    logic                  pipe_vld;

    // First stage captures the array word; second stage drives Q. The
    // second stage keeps advancing during INIT so an in-flight read
    // still completes.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
        pipe_data <= '0;
        pipe_vld  <= 1'b0;
        Q         <= '0;
        q_vld     <= 1'b0;
      end else begin
        pipe_vld <= user_rd;
        if (user_rd) begin
          pipe_data <= mem[A];
        end
        q_vld <= pipe_vld;
        if (pipe_vld) begin
          Q <= pipe_data;
        end
      end
    end

  end

endmodule

// File: doc/ct_spsram_param_clr.md
Name: ct_spsram_param_clr

Overview:
- Parametrised single-port SRAM block for MMU/cache arrays: configurable depth, width and write-mask granularity.
- Optional read-output pipeline register and a hardware clear engine that writes zero to every entry after reset or on request.
- Memory side keeps the active-low CEN/GWEN/WEN SRAM interface.
- Adds a read-data-valid strobe and an init-busy indication for the owning controller.

Parameters:
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 196, data bits per entry.
- WE_WIDTH, 196, write-mask bits. Must divide DATA_WIDTH. Mask bit i covers data bits [i*G +: G], where G = DATA_WIDTH/WE_WIDTH.
- RD_PIPE, 0, 0 = Q at the clock edge after the read; 1 = one extra output register stage.
- INIT_EN, 1, 1 = clear engine active; 0 = clear engine removed, init_busy tied 0, clr_req ignored.

Ports:
- forever_cpuclk  in  1  clock.
- cpurst_b  in  1  asynchronous active-low reset.
- CEN  in  1  chip enable, active low.
- GWEN  in  1  global write enable, active low; 1 = read.
- A  in  ADDR_WIDTH  address.
- D  in  DATA_WIDTH  write data.
- WEN  in  WE_WIDTH  per-group write enable, active low.
- Q  out  DATA_WIDTH  read data.
- q_vld  out  1  one-cycle pulse when Q carries new read data.
- clr_req  in  1  single-cycle request to zero the whole array.
- init_busy  out  1  clear in progress; user accesses are dropped.

Behaviour:
- Reset (cpurst_b=0), asynchronous: Q=0, q_vld=0, pipeline register=0, clear counter=0. FSM goes to INIT if INIT_EN=1, otherwise to READY. Array contents are not reset.
- FSM states:
  - INIT: each cycle writes 0 to entry cnt, then cnt+1. At cnt = DEPTH-1 the last write occurs and the FSM goes to READY. Duration is exactly DEPTH cycles. init_busy = 1 in INIT.
  - READY: normal access; init_busy = 0.
  - READY->INIT on clr_req=1 (INIT_EN=1). A user access presented in the same cycle as clr_req is executed. Clearing starts the following cycle with cnt=0.
  - clr_req while already in INIT: ignored; the sweep does not restart.
- User access in READY, sampled at the rising edge with CEN=0:
  - Write (GWEN=0): for each i with WEN[i]=0, mem[A] group i <= D group i. Groups with WEN[i]=1 keep their value. Q and q_vld are unchanged. All WEN bits 1 gives no array change.
  - Read (GWEN=1): RD_PIPE=0 gives Q=mem[A] and q_vld=1 after that edge (latency 1). RD_PIPE=1 gives latency 2. WEN is ignored on reads.
  - CEN=1: no access. Q holds its last value; q_vld=0.
- Accesses in INIT are discarded entirely: no write, no q_vld.
- A read issued in the cycle clr_req is accepted still returns pre-clear data. With RD_PIPE=1, q_vld for a read already in the pipeline still fires during INIT.
- Q holds its value indefinitely between reads. Q is never modified by writes or by the clear sweep.
- Counter wrap: cnt is ADDR_WIDTH bits. The terminal compare is on all-ones; there is no overflow state.
- Reset asserted mid-INIT aborts the sweep. After deassertion the sweep restarts from entry 0. Reset mid-read drops the pending q_vld.
- Width rules: all data paths are DATA_WIDTH. A DATA_WIDTH % WE_WIDTH != 0 configuration is illegal and is flagged by an elaboration-time check.

Test Plan:
- Defaults, release cpurst_b: init_busy = 1 for exactly 256 cycles, then 0. Read A=0x00, 0x7F and 0xFF: Q = 0 each, q_vld pulses 1 cycle after each read.
- Write A=0x12, D=all-ones, WEN=0, then read 0x12: Q = all-ones. Write D=0 with only WEN[3:0]=0, then read: Q[3:0]=0 and the remaining bits are 1. Then set CEN=1 for 5 cycles: Q is held and q_vld=0.
- With RD_PIPE=1, read 0x12: q_vld and Q appear 2 edges after the read. Back-to-back reads of 0x12 and 0x13 give q_vld on consecutive cycles with matching data.
- Fill entries with 0xA5 patterns, then pulse clr_req together with a read of 0x05: the read returns 0xA5 data. init_busy = 1 for 256 cycles, and a write issued during INIT is dropped. All entries read 0 afterwards.
- Pulse clr_req again at cycle 100 of INIT: the sweep still ends at cycle 256. Assert cpurst_b=0 at cycle 50 of INIT: after release, init_busy lasts a full 256 cycles.
- WE_WIDTH=4, DATA_WIDTH=196 (G=49): WEN=4'b1101 writes only bits [97:49], confirmed by read-back.
